// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: execute-stage producer classes
// and the default pipeline latencies.
package hazard_pkg;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'd0,
        CLS_LOAD = 2'd1,
        CLS_MUL  = 2'd2,
        CLS_DIV  = 2'd3
    } ex_class_e;

    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_LAT_W    = 3;
    localparam int DEF_LOAD_LAT = 1;
    localparam int DEF_MUL_LAT  = 3;

endpackage

// File: rtl/reg_countdown.sv
// One scoreboard slot: a down-counter that is reloaded when a long-latency
// producer for its register leaves EX and reports whether it is still pending.
module reg_countdown #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic             nonzero
);

    logic [LAT_W-1:0] cnt_reg;

    // Reload has priority over the decrement; counting stops at zero.
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - LAT_W'(1);
        end
    end

    assign nonzero = (cnt_reg != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Interlock unit: tracks results not yet forwardable (loads, multiplies,
// the variable-latency divider) and stalls Decode on RAW, WAW and divider
// structural hazards.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int LAT_W    = DEF_LAT_W,
    parameter int LOAD_LAT = DEF_LOAD_LAT,
    parameter int MUL_LAT  = DEF_MUL_LAT
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_flush,
    input  logic                  i_ex_valid,
    input  logic [ADDR_W-1:0]     i_ex_rd_addr,
    input  logic                  i_ex_rd_wren,
    input  logic [1:0]            i_ex_class,
    input  logic                  i_div_done,
    input  logic [ADDR_W-1:0]     i_dec_rs1_addr,
    input  logic [ADDR_W-1:0]     i_dec_rs2_addr,
    input  logic                  i_dec_rs1_used,
    input  logic                  i_dec_rs2_used,
    input  logic [ADDR_W-1:0]     i_dec_rd_addr,
    input  logic                  i_dec_rd_wren,
    input  logic                  i_dec_is_div,
    output logic                  o_stall,
    output logic                  o_div_busy,
    output logic [(1<<ADDR_W)-1:0] o_pending_mask
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [LAT_W-1:0] LOAD_CNT = LAT_W'(LOAD_LAT - 1);
    localparam logic [LAT_W-1:0] MUL_CNT  = LAT_W'(MUL_LAT - 1);

    ex_class_e        ex_class;
    logic             capture;
    logic             is_load, is_mul, is_div;
    logic             cnt_load_en;
    logic [LAT_W-1:0] cnt_load_val;
    logic             hit_any;

    logic [NREG-1:0]  cnt_nz;
    logic [NREG-1:0]  busy_vec;
    logic [NREG-1:0]  hit_vec;
    logic [NREG-1:0]  hazard_vec;

    logic             div_busy_reg;
    logic [ADDR_W-1:0] div_rd_reg;

    logic             raw1, raw2, waw, div_struct;

    assign ex_class = ex_class_e'(i_ex_class);
    assign is_load  = (ex_class == CLS_LOAD);
    assign is_mul   = (ex_class == CLS_MUL);
    assign is_div   = (ex_class == CLS_DIV);

    // A flushed EX instruction, a bubble, or a write to x0 never enters the board.
    assign capture = i_ex_valid & i_ex_rd_wren & (i_ex_rd_addr != '0) & ~i_flush;

    // Only producers needing more than one extra cycle occupy a counter; a
    // latency-1 producer is covered entirely by the same-cycle EX hit.
    assign cnt_load_en  = capture & ((is_load & (LOAD_LAT > 1)) | (is_mul & (MUL_LAT > 1)));
    assign cnt_load_val = is_load ? LOAD_CNT : MUL_CNT;

    // Latency-0 producers forward straight out of EX and never hit.
    assign hit_any = capture & ((is_load & (LOAD_LAT >= 1)) | (is_mul & (MUL_LAT >= 1)) | is_div);

    assign cnt_nz[0]   = 1'b0;
    assign busy_vec[0] = 1'b0;
    assign hit_vec[0]  = 1'b0;

    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_slot
            logic sel;
            assign sel = (i_ex_rd_addr == ADDR_W'(gi));

            reg_countdown #(
                .LAT_W(LAT_W)
            ) u_cnt (
                .clk     (i_clk),
                .srst    (i_reset),
                .load    (cnt_load_en & sel),
                .load_val(cnt_load_val),
                .nonzero (cnt_nz[gi])
            );

            // The divider releases its destination in the done cycle itself.
            assign busy_vec[gi] = cnt_nz[gi] |
                                  (div_busy_reg & (div_rd_reg == ADDR_W'(gi)) & ~i_div_done);
            assign hit_vec[gi]  = hit_any & sel;
        end
    endgenerate

    assign hazard_vec = busy_vec | hit_vec;

    // Divider ownership: a new divide wins over a retiring one in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            div_busy_reg <= 1'b0;
            div_rd_reg   <= '0;
        end else if (capture & is_div) begin
            div_busy_reg <= 1'b1;
            div_rd_reg   <= i_ex_rd_addr;
        end else if (i_div_done) begin
            div_busy_reg <= 1'b0;
        end
    end

    assign raw1       = i_dec_rs1_used & hazard_vec[i_dec_rs1_addr];
    assign raw2       = i_dec_rs2_used & hazard_vec[i_dec_rs2_addr];
    assign waw        = i_dec_rd_wren  & hazard_vec[i_dec_rd_addr];
    assign div_struct = i_dec_is_div & ((div_busy_reg & ~i_div_done) | (capture & is_div));

    assign o_stall        = ~i_reset & (raw1 | raw2 | waw | div_struct);
    assign o_div_busy     = div_busy_reg;
    assign o_pending_mask = busy_vec;

endmodule
